micro_sequencer: RTL
====================

# micro_sequencer

Parametrised microprogram sequencer for the multi-cycle RISC-V control path; successor to the fixed 4-bit, two-ROM microcounter. It holds the current microstate and selects the next one from: increment, fetch, N external dispatch tables, direct jump, or call/return through a small return-address stack. It adds stall, undefined-opcode/stack fault trapping and a retired-instruction counter. It sits between the opcode decode ROMs and the control-signal ROM, which is indexed by `curr_state`.

## Interface
- `STATE_W`, 4: microstate width.
- `NUM_DISP`, 2: number of dispatch tables (1..4).
- `STACK_DEPTH`, 2: return-stack entries (1..8).
- `CNT_W`, 32: instruction counter width.
- `IDLE_STATE`, 0: reset state.
- `FETCH_STATE`, 1: instruction-fetch microstate.
- `TRAP_STATE`, 15: fault handler microstate.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `stall`  in  1  hold everything this cycle.
- `seq_op`  in  3  next-state op: 0 SEQ, 1 FETCH, 2 DISP, 3 JUMP, 4 CALL, 5 RET, 6/7 reserved.
- `disp_sel`  in  2  dispatch table index for DISP.
- `disp_state`  in  NUM_DISP*STATE_W  per-table target (table k at bits [k*STATE_W +: STATE_W]).
- `disp_valid`  in  NUM_DISP  per-table "opcode defined" flag.
- `target`  in  STATE_W  JUMP/CALL target.
- `curr_state`  out  STATE_W  registered microstate.
- `next_state`  out  STATE_W  combinational next microstate.
- `inst_count`  out  CNT_W  instructions started.
- `stack_level`  out  log2(STACK_DEPTH)+1  occupied stack entries.
- `fault`  out  1  registered one-cycle fault pulse.
- `fault_code`  out  2  0 none, 1 undefined dispatch, 2 stack overflow, 3 stack underflow or reserved op; holds last value until next fault or reset.

## Operation
- next_state (comb., `stall` ignored): SEQ → curr+1 mod 2^STATE_W; FETCH → FETCH_STATE; DISP → disp_state[disp_sel] when disp_valid[disp_sel], else TRAP_STATE; JUMP → target; CALL → target when stack not full, else TRAP_STATE; RET → top of stack when non-empty, else TRAP_STATE; 6/7 → TRAP_STATE.
- DISP with disp_sel ≥ NUM_DISP counts as undefined (code 1).
- CALL pushes curr+1 (mod 2^STATE_W) and increments stack_level. RET pops and decrements it. LIFO order.
- Faulting ops never modify the stack.
- When not stalled: at the clock edge, curr_state ← next_state. On a fault condition, fault=1 for exactly that following cycle and fault_code is updated.
- inst_count increments (wrapping at 2^CNT_W) on every non-stalled edge where next_state == FETCH_STATE. This includes SEQ, JUMP or RET landing on FETCH_STATE.
- stall=1: curr_state, stack, inst_count and fault_code hold; fault drives 0; no push, pop or count.

## Timing
- Reset (asynchronous, immediate): curr_state=IDLE_STATE, inst_count=0, stack_level=0, fault=0, fault_code=0. Stack contents are don't-care.
- Reset mid-operation discards the stack and any pending fault.
- First edge after reset release applies the op normally.
- next_state is valid in the same cycle as the inputs. curr_state has 1-cycle latency. The control ROM sees the new state one cycle after the op.
- A CALL at full stack and a RET at empty stack each trap in one cycle.
- A RET immediately after a CALL returns to the pushed address. No bypass hazards, since the push is registered before the RET is sampled.
- Wrap: SEQ from 2^STATE_W−1 goes to 0 with no fault.

## Test plan
- Reset then SEQ ×3 with defaults: curr_state 0→1→2→3. inst_count=1 after the first edge (entered state 1).
- DISP, disp_sel=0, disp_state={4'd5,4'd3}, disp_valid=2'b11: next_state=3, curr_state=3 next cycle. disp_sel=1 gives 5. disp_valid=2'b10 with sel=0: curr_state=15, fault pulse, fault_code=1.
- CALL target=8 from state 4, then CALL target=10 from state 8, then a third CALL: stack_level 1,2. Third CALL traps to 15 with code 2 and stack_level stays 2. Then RET ×2 gives 9 then 5, and a further RET traps with code 3.
- stall high 3 cycles with seq_op=FETCH: curr_state, inst_count and stack_level unchanged, fault=0. Deassert: state=1, count+1.
- Assert reset asynchronously mid-cycle with stack_level=2 and fault_code=2: outputs clear before the next edge. Counter restarts from 0.
- SEQ from state 15: wraps to 0 with fault=0. seq_op=6: traps to 15 with code 3.

Source files
------------

// File: rtl/micro_sequencer.sv
// micro_sequencer: microprogram sequencer with dispatch tables, return stack, fault trapping and instruction counter.
// Ports:
//   clk_i          clock, rising edge
//   reset_i        asynchronous active-high reset
//   stall_i        hold all state this cycle
//   seq_op_i       0 SEQ, 1 FETCH, 2 DISP, 3 JUMP, 4 CALL, 5 RET, 6/7 reserved
//   disp_sel_i     dispatch table index for DISP
//   disp_state_i   packed per-table dispatch targets
//   disp_valid_i   per-table opcode-defined flags
//   target_i       JUMP/CALL target
//   curr_state_o   registered microstate
//   next_state_o   combinational next microstate
//   inst_count_o   instructions started
//   stack_level_o  occupied return-stack entries
//   fault_o        one-cycle fault pulse
//   fault_code_o   last fault: 1 undefined dispatch, 2 overflow, 3 underflow/reserved op
module micro_sequencer #(
    parameter int STATE_W     = 4,
    parameter int NUM_DISP    = 2,
    parameter int STACK_DEPTH = 2,
    parameter int CNT_W       = 32,
    parameter int IDLE_STATE  = 0,
    parameter int FETCH_STATE = 1,
    parameter int TRAP_STATE  = 15,
    localparam int LVL_W      = $clog2(STACK_DEPTH) + 1
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        stall_i,
    input  logic [2:0]                  seq_op_i,
    input  logic [1:0]                  disp_sel_i,
    input  logic [NUM_DISP*STATE_W-1:0] disp_state_i,
    input  logic [NUM_DISP-1:0]         disp_valid_i,
    input  logic [STATE_W-1:0]          target_i,
    output logic [STATE_W-1:0]          curr_state_o,
    output logic [STATE_W-1:0]          next_state_o,
    output logic [CNT_W-1:0]            inst_count_o,
    output logic [LVL_W-1:0]            stack_level_o,
    output logic                        fault_o,
    output logic [1:0]                  fault_code_o
);
    typedef enum logic [2:0] {
        OP_SEQ, OP_FETCH, OP_DISP, OP_JUMP, OP_CALL, OP_RET
    } op_e;

    localparam logic [STATE_W-1:0] FETCH_S = STATE_W'(FETCH_STATE);
    localparam logic [STATE_W-1:0] TRAP_S  = STATE_W'(TRAP_STATE);

    logic [STATE_W-1:0] state_q, state_d, inc, disp_st, top;
    logic [STATE_W-1:0] stack_q [STACK_DEPTH];
    logic [CNT_W-1:0]   cnt_q;
    logic [LVL_W-1:0]   lvl_q;
    logic [1:0]         code_q, code_d;
    logic               fault_q, disp_ok, full, empty, push, pop;

    always_comb begin
        inc     = state_q + STATE_W'(1);
        disp_ok = 1'b0;
        disp_st = '0;
        // selects beyond NUM_DISP leave disp_ok low and so trap as undefined
        for (int k = 0; k < NUM_DISP; k++)
            if (disp_sel_i == 2'(k)) begin
                disp_ok = disp_valid_i[k];
                disp_st = disp_state_i[k*STATE_W +: STATE_W];
            end
        top = '0;
        for (int i = 0; i < STACK_DEPTH; i++)
            if (lvl_q == LVL_W'(i + 1)) top = stack_q[i];
        full    = lvl_q == LVL_W'(STACK_DEPTH);
        empty   = lvl_q == '0;
        state_d = TRAP_S;
        code_d  = 2'd0;
        push    = 1'b0;
        pop     = 1'b0;
        case (seq_op_i)
            OP_SEQ:   state_d = inc;
            OP_FETCH: state_d = FETCH_S;
            OP_DISP:  begin
                state_d = disp_ok ? disp_st : TRAP_S;
                code_d  = disp_ok ? 2'd0 : 2'd1;
            end
            OP_JUMP:  state_d = target_i;
            OP_CALL:  begin
                state_d = full ? TRAP_S : target_i;
                code_d  = full ? 2'd2 : 2'd0;
                push    = !full;
            end
            OP_RET:   begin
                state_d = empty ? TRAP_S : top;
                code_d  = empty ? 2'd3 : 2'd0;
                pop     = !empty;
            end
            default:  code_d = 2'd3;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i)
        if (reset_i) begin
            state_q <= STATE_W'(IDLE_STATE);
            cnt_q   <= '0;
            lvl_q   <= '0;
            fault_q <= 1'b0;
            code_q  <= 2'd0;
        end else if (stall_i) begin
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            fault_q <= code_d != 2'd0;
            if (code_d != 2'd0) code_q <= code_d;
            if (state_d == FETCH_S) cnt_q <= cnt_q + CNT_W'(1);
            lvl_q <= push ? lvl_q + LVL_W'(1) : pop ? lvl_q - LVL_W'(1) : lvl_q;
        end

    // stack contents need no reset: stack_level alone decides what is valid
    always_ff @(posedge clk_i)
        if (!stall_i && push)
            for (int i = 0; i < STACK_DEPTH; i++)
                if (lvl_q == LVL_W'(i)) stack_q[i] <= inc;

    assign curr_state_o  = state_q;
    assign next_state_o  = state_d;
    assign inst_count_o  = cnt_q;
    assign stack_level_o = lvl_q;
    assign fault_o       = fault_q;
    assign fault_code_o  = code_q;
endmodule
